// File: rtl/ebpf_seq_ctl.sv
// eBPF core control sequencer: fetch/decode/pending-handshake state machine,
// instruction pointer, run/halt/error status and the ticks cycle counter.
module ebpf_seq_ctl #(
  parameter int MAX_PGM_WORDS = 4096,
  parameter int PGM_AW        = 12,
  parameter int PEND_TIMEOUT  = 1024,
  parameter int TICKS_W       = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [7:0]         r_ctl,
  output logic [7:0]         r_status,
  output logic [TICKS_W-1:0] ticks,
  output logic [PGM_AW-1:0]  ip,
  output logic [2:0]         state,
  output logic [1:0]         err_code,
  output logic               pgm_req,
  input  logic               pgm_ack,
  input  logic [2:0]         dec_class,
  input  logic               br_taken,
  input  logic [15:0]        br_offset,
  output logic               data_req,
  input  logic               data_ack,
  input  logic               data_err,
  output logic               div_start,
  input  logic               div_done,
  output logic               call_stb,
  input  logic               call_done,
  output logic               wb_en
);

  typedef enum logic [2:0] {
    OP_FETCH     = 3'd0,
    DECODE       = 3'd1,
    DATA_FETCH   = 3'd2,
    DIV_PENDING  = 3'd3,
    CALL_PENDING = 3'd4,
    HALT         = 3'd5
  } state_e;

  localparam logic [2:0] CLS_ALU  = 3'd0;
  localparam logic [2:0] CLS_JMP  = 3'd1;
  localparam logic [2:0] CLS_MEM  = 3'd2;
  localparam logic [2:0] CLS_DIV  = 3'd3;
  localparam logic [2:0] CLS_CALL = 3'd4;
  localparam logic [2:0] CLS_EXIT = 3'd5;
  localparam logic [2:0] CLS_LDDW = 3'd6;

  localparam logic [1:0] ERR_ILLEGAL  = 2'd0;
  localparam logic [1:0] ERR_IP_RANGE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_DATA     = 2'd3;

  localparam int IPX_W = PGM_AW + 17;
  localparam int CNT_W = $clog2(PEND_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]        PEND_LAST = CNT_W'(PEND_TIMEOUT - 1);
  localparam logic signed [IPX_W-1:0] IP_LIMIT  = IPX_W'(MAX_PGM_WORDS);
  localparam logic signed [IPX_W-1:0] STEP1     = IPX_W'(1);
  localparam logic signed [IPX_W-1:0] STEP2     = IPX_W'(2);

  state_e             state_q, state_d;
  logic [PGM_AW-1:0]  ip_q, ip_d;
  logic [TICKS_W-1:0] ticks_q, ticks_d;
  logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic               run_q;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  logic                    active;
  logic                    done_now;
  logic                    advance;
  logic                    commit;
  logic                    halt_req;
  logic                    halt_err;
  logic [1:0]              halt_code;
  logic signed [IPX_W-1:0] off_ext;
  logic signed [IPX_W-1:0] ip_delta;
  logic signed [IPX_W-1:0] ip_target;
  logic                    ip_bad;
  logic                    unused_ctl;

  assign active     = r_ctl[0] & ~sys_rst;
  assign unused_ctl = ^r_ctl[7:1];
  assign off_ext    = {{(IPX_W-16){br_offset[15]}}, br_offset};

  always_comb begin
    ip_delta = STEP1;
    if (state_q == DECODE) begin
      if (dec_class == CLS_LDDW) begin
        ip_delta = STEP2;
      end else if (dec_class == CLS_JMP && br_taken) begin
        ip_delta = off_ext + STEP1;
      end
    end
  end

  // Wide signed sum so that negative or oversized targets are caught instead of wrapping.
  assign ip_target = $signed({{(IPX_W-PGM_AW){1'b0}}, ip_q}) + ip_delta;
  assign ip_bad    = ip_target[IPX_W-1] | (ip_target >= IP_LIMIT);

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    pend_cnt_d = pend_cnt_q;
    ticks_d    = ticks_q;
    pgm_req    = 1'b0;
    data_req   = 1'b0;
    div_start  = 1'b0;
    call_stb   = 1'b0;
    wb_en      = 1'b0;
    advance    = 1'b0;
    commit     = 1'b0;
    halt_req   = 1'b0;
    halt_err   = 1'b0;
    halt_code  = ERR_ILLEGAL;
    done_now   = ((state_q == DATA_FETCH)   & data_ack) |
                 ((state_q == DIV_PENDING)  & div_done) |
                 ((state_q == CALL_PENDING) & call_done);

    case (state_q)
      OP_FETCH: begin
        pgm_req = 1'b1;
        if (pgm_ack) state_d = DECODE;
      end
      DECODE: begin
        pend_cnt_d = '0;
        case (dec_class)
          CLS_ALU, CLS_LDDW: begin
            advance = 1'b1;
            commit  = 1'b1;
          end
          CLS_JMP:  advance = 1'b1;
          CLS_MEM:  state_d = DATA_FETCH;
          CLS_DIV: begin
            div_start = 1'b1;
            state_d   = DIV_PENDING;
          end
          CLS_CALL: begin
            call_stb = 1'b1;
            state_d  = CALL_PENDING;
          end
          CLS_EXIT: halt_req = 1'b1;
          default: begin
            halt_req  = 1'b1;
            halt_err  = 1'b1;
            halt_code = ERR_ILLEGAL;
          end
        endcase
      end
      DATA_FETCH, DIV_PENDING, CALL_PENDING: begin
        data_req = (state_q == DATA_FETCH);
        // A bus error outranks a simultaneous ack.
        if (state_q == DATA_FETCH && data_err) begin
          halt_req  = 1'b1;
          halt_err  = 1'b1;
          halt_code = ERR_DATA;
        end else if (done_now) begin
          advance = 1'b1;
          commit  = 1'b1;
        end else if (pend_cnt_q == PEND_LAST) begin
          halt_req  = 1'b1;
          halt_err  = 1'b1;
          halt_code = ERR_TIMEOUT;
        end else begin
          pend_cnt_d = pend_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // An out-of-range target halts without committing the write-back.
    if (advance) begin
      if (ip_bad) begin
        halt_req  = 1'b1;
        halt_err  = 1'b1;
        halt_code = ERR_IP_RANGE;
      end else begin
        ip_d    = ip_target[PGM_AW-1:0];
        wb_en   = commit;
        state_d = OP_FETCH;
      end
    end

    if (halt_req) begin
      state_d = HALT;
      if (halt_err) begin
        err_d      = 1'b1;
        err_code_d = halt_code;
      end
    end

    if (state_q != HALT && ticks_q != '1) ticks_d = ticks_q + TICKS_W'(1);

    // Dropping run abandons everything, including acks arriving in this very cycle.
    if (!active) begin
      state_d    = OP_FETCH;
      ip_d       = '0;
      err_d      = 1'b0;
      err_code_d = ERR_ILLEGAL;
      pend_cnt_d = '0;
      ticks_d    = '0;
      pgm_req    = 1'b0;
      data_req   = 1'b0;
      div_start  = 1'b0;
      call_stb   = 1'b0;
      wb_en      = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= OP_FETCH;
      ip_q       <= '0;
      ticks_q    <= '0;
      pend_cnt_q <= '0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_ILLEGAL;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      ticks_q    <= ticks_d;
      pend_cnt_q <= pend_cnt_d;
      run_q      <= r_ctl[0];
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign state    = state_q;
  assign ip       = ip_q;
  assign ticks    = ticks_q;
  assign err_code = err_code_q;
  assign r_status = {5'b00000, err_q, (state_q == HALT), run_q};

endmodule

// File: tb/tb_ebpf_seq_ctl.sv
// Self-checking bench for ebpf_seq_ctl: directed scenarios plus a random instruction
// stream, compared against an instruction-level reference model.
module tb_ebpf_seq_ctl;

  localparam int PEND = 16;
  localparam int MAXW = 4096;
  localparam int C_ALU = 0, C_JMP = 1, C_MEM = 2, C_DIV = 3;
  localparam int C_CALL = 4, C_EXIT = 5, C_LDDW = 6, C_ILL = 7;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  r_ctl;
  logic        pgm_ack;
  logic [2:0]  dec_class;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        data_ack, data_err, div_done, call_done;

  logic [7:0]  r_status;
  logic [63:0] ticks;
  logic [11:0] ip;
  logic [2:0]  state;
  logic [1:0]  err_code;
  logic        pgm_req, data_req, div_start, call_stb, wb_en;

  logic [7:0]  status4;
  logic [3:0]  ticks4;
  logic [11:0] ip4;
  logic [2:0]  state4;
  logic [1:0]  err4;
  logic        pgmReq4, dataReq4, divStart4, callStb4, wbEn4;

  int errors = 0;
  int checks = 0;
  int wbSeen = 0, divSeen = 0, callSeen = 0;
  int wbSeen4 = 0, divSeen4 = 0, callSeen4 = 0;

  int     mIp;
  longint mTicks;
  bit     mHalt, mErr;
  int     mCode;
  int     mWb = 0, mDiv = 0, mCall = 0;

  ebpf_seq_ctl #(.MAX_PGM_WORDS(MAXW), .PGM_AW(12), .PEND_TIMEOUT(PEND), .TICKS_W(64)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .r_ctl(r_ctl), .r_status(r_status), .ticks(ticks),
    .ip(ip), .state(state), .err_code(err_code), .pgm_req(pgm_req), .pgm_ack(pgm_ack),
    .dec_class(dec_class), .br_taken(br_taken), .br_offset(br_offset), .data_req(data_req),
    .data_ack(data_ack), .data_err(data_err), .div_start(div_start), .div_done(div_done),
    .call_stb(call_stb), .call_done(call_done), .wb_en(wb_en)
  );

  ebpf_seq_ctl #(.MAX_PGM_WORDS(MAXW), .PGM_AW(12), .PEND_TIMEOUT(PEND), .TICKS_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .r_ctl(r_ctl), .r_status(status4), .ticks(ticks4),
    .ip(ip4), .state(state4), .err_code(err4), .pgm_req(pgmReq4), .pgm_ack(pgm_ack),
    .dec_class(dec_class), .br_taken(br_taken), .br_offset(br_offset), .data_req(dataReq4),
    .data_ack(data_ack), .data_err(data_err), .div_start(divStart4), .div_done(div_done),
    .call_stb(callStb4), .call_done(call_done), .wb_en(wbEn4)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (wb_en === 1'b1) wbSeen++;
    if (div_start === 1'b1) divSeen++;
    if (call_stb === 1'b1) callSeen++;
    if (wbEn4 === 1'b1) wbSeen4++;
    if (divStart4 === 1'b1) divSeen4++;
    if (callStb4 === 1'b1) callSeen4++;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    longint sat4;
    sat4 = (mTicks > 15) ? 15 : mTicks;
    checkVal({tag, ".ip"}, 64'(ip), 64'(mIp));
    checkVal({tag, ".ip4"}, 64'(ip4), 64'(mIp));
    checkVal({tag, ".ticks"}, ticks, 64'(mTicks));
    checkVal({tag, ".ticks4"}, 64'(ticks4), 64'(sat4));
    checkVal({tag, ".status"}, 64'(r_status), 64'({5'b0, mErr, mHalt, 1'b1}));
    checkVal({tag, ".status4"}, 64'(status4), 64'({5'b0, mErr, mHalt, 1'b1}));
    checkVal({tag, ".state"}, 64'(state), mHalt ? 64'd5 : 64'd0);
    checkVal({tag, ".state4"}, 64'(state4), mHalt ? 64'd5 : 64'd0);
    checkVal({tag, ".pgm_req"}, 64'(pgm_req), 64'(!mHalt));
    checkVal({tag, ".pgm_req4"}, 64'(pgmReq4), 64'(!mHalt));
    if (mErr) begin
      checkVal({tag, ".err_code"}, 64'(err_code), 64'(mCode));
      checkVal({tag, ".err_code4"}, 64'(err4), 64'(mCode));
    end
    checkVal({tag, ".wb_count"}, 64'(wbSeen), 64'(mWb));
    checkVal({tag, ".div_count"}, 64'(divSeen), 64'(mDiv));
    checkVal({tag, ".call_count"}, 64'(callSeen), 64'(mCall));
    checkVal({tag, ".wb_count4"}, 64'(wbSeen4), 64'(mWb));
    checkVal({tag, ".div_count4"}, 64'(divSeen4), 64'(mDiv));
    checkVal({tag, ".call_count4"}, 64'(callSeen4), 64'(mCall));
  endtask

  task automatic modelHalt(input bit isErr, input int code);
    mHalt = 1'b1;
    mErr  = isErr;
    if (isErr) mCode = code;
  endtask

  // Instruction-level reference: total cycles spent, resulting ip and commit/halt outcome.
  task automatic modelInstr(input int cls, input bit taken, input int off, input int fw,
                            input int cw, input bit dErr, output bit expWb);
    bit pend, timeout, adv, commit;
    int delta, tgt;
    pend    = (cls == C_MEM) || (cls == C_DIV) || (cls == C_CALL);
    timeout = pend && (cw >= PEND);
    mTicks += fw + 2 + (pend ? (timeout ? PEND : cw + 1) : 0);
    adv = 1'b0; commit = 1'b0; delta = 1; expWb = 1'b0;
    if (cls == C_DIV) mDiv++;
    if (cls == C_CALL) mCall++;
    case (cls)
      C_ALU:  begin adv = 1'b1; commit = 1'b1; end
      C_JMP:  begin adv = 1'b1; delta = 1 + (taken ? off : 0); end
      C_LDDW: begin adv = 1'b1; commit = 1'b1; delta = 2; end
      C_MEM: begin
        if (timeout) modelHalt(1'b1, 2);
        else if (dErr) modelHalt(1'b1, 3);
        else begin adv = 1'b1; commit = 1'b1; end
      end
      C_DIV, C_CALL: begin
        if (timeout) modelHalt(1'b1, 2);
        else begin adv = 1'b1; commit = 1'b1; end
      end
      C_EXIT: modelHalt(1'b0, 0);
      default: modelHalt(1'b1, 0);
    endcase
    if (adv) begin
      tgt = mIp + delta;
      if (tgt < 0 || tgt >= MAXW) modelHalt(1'b1, 1);
      else begin
        mIp = tgt;
        if (commit) begin mWb++; expWb = 1'b1; end
      end
    end
  endtask

  // Plays one instruction through fetch, decode and any pending handshake.
  task automatic applyStimulus(input int cls, input bit taken, input int off, input int fw,
                               input int cw, input bit dErr, input bit dBoth);
    bit expWb, pend, timeout;
    pend    = (cls == C_MEM) || (cls == C_DIV) || (cls == C_CALL);
    timeout = pend && (cw >= PEND);
    modelInstr(cls, taken, off, fw, cw, dErr, expWb);
    pgm_ack = 1'b0;
    repeat (fw) tick();
    pgm_ack   = 1'b1;
    dec_class = 3'(cls);
    br_taken  = taken;
    br_offset = 16'(off);
    tick();
    pgm_ack = 1'b0;
    tick();
    if (pend) begin
      if (cls == C_MEM) begin
        checkVal("data_req_pending", 64'(data_req), 64'd1);
        checkVal("data_req4_pending", 64'(dataReq4), 64'd1);
      end
      if (timeout) begin
        repeat (PEND) tick();
      end else begin
        repeat (cw) tick();
        if (cls == C_MEM) begin
          data_err = dErr;
          data_ack = !dErr || dBoth;
        end else if (cls == C_DIV) begin
          div_done = 1'b1;
        end else begin
          call_done = 1'b1;
        end
        #1;
        checkVal("wb_en_done", 64'(wb_en), 64'(expWb));
        tick();
        data_ack = 1'b0; data_err = 1'b0; div_done = 1'b0; call_done = 1'b0;
      end
    end
  endtask

  task automatic runInstr(input string tag, input int cls, input bit taken, input int off,
                          input int fw, input int cw, input bit dErr, input bit dBoth);
    applyStimulus(cls, taken, off, fw, cw, dErr, dBoth);
    if (mHalt) repeat (3) tick();
    checkOutput(tag);
  endtask

  task automatic restartRun(input string tag);
    r_ctl = 8'h00;
    tick();
    checkVal({tag, ".idle_state"}, 64'(state), 64'd0);
    checkVal({tag, ".idle_ip"}, 64'(ip), 64'd0);
    checkVal({tag, ".idle_ticks"}, ticks, 64'd0);
    checkVal({tag, ".idle_status"}, 64'(r_status), 64'd0);
    checkVal({tag, ".idle_err_code"}, 64'(err_code), 64'd0);
    checkVal({tag, ".idle_pgm_req"}, 64'(pgm_req), 64'd0);
    r_ctl = 8'h01;
    #1;
    checkVal({tag, ".run_pgm_req"}, 64'(pgm_req), 64'd1);
    mIp = 0; mTicks = 0; mHalt = 1'b0; mErr = 1'b0; mCode = 0;
  endtask

  initial begin
    sys_rst = 1'b1; r_ctl = 8'h01; pgm_ack = 1'b0; dec_class = 3'd0; br_taken = 1'b0;
    br_offset = 16'd0; data_ack = 1'b0; data_err = 1'b0; div_done = 1'b0; call_done = 1'b0;
    tick();
    tick();
    checkVal("rst.state", 64'(state), 64'd0);
    checkVal("rst.ip", 64'(ip), 64'd0);
    checkVal("rst.ticks", ticks, 64'd0);
    checkVal("rst.status", 64'(r_status), 64'd0);
    checkVal("rst.err_code", 64'(err_code), 64'd0);
    checkVal("rst.pgm_req", 64'(pgm_req), 64'd0);
    sys_rst = 1'b0;
    mIp = 0; mTicks = 0; mHalt = 1'b0; mErr = 1'b0; mCode = 0;

    runInstr("t1_alu0", C_ALU, 0, 0, 0, 0, 0, 0);
    runInstr("t1_alu1", C_ALU, 0, 0, 0, 0, 0, 0);
    runInstr("t1_alu2", C_ALU, 0, 0, 0, 0, 0, 0);
    runInstr("t1_exit", C_EXIT, 0, 0, 0, 0, 0, 0);
    checkVal("t1_ticks_frozen", ticks, 64'd8);
    checkVal("t1_status", 64'(r_status), 64'h03);
    checkVal("t1_wb_pulses", 64'(wbSeen), 64'd3);

    restartRun("t2");
    for (int i = 0; i < 5; i++) runInstr("t2_alu", C_ALU, 0, 0, 0, 0, 0, 0);
    runInstr("t2_jmp_back", C_JMP, 1, -3, 1, 0, 0, 0);
    checkVal("t2_ip_after_jmp", 64'(ip), 64'd3);
    runInstr("t2_jmp_not_taken", C_JMP, 0, 99, 0, 0, 0, 0);
    runInstr("t2_jmp_far", C_JMP, 1, 5000, 0, 0, 0, 0);
    checkVal("t2_status_err", 64'(r_status), 64'h07);
    checkVal("t2_ip_held", 64'(ip), 64'd4);

    restartRun("t3");
    runInstr("t3_div", C_DIV, 0, 0, 0, 9, 0, 0);
    checkVal("t3_ip", 64'(ip), 64'd1);

    restartRun("t4");
    runInstr("t4_call_timeout", C_CALL, 0, 0, 0, PEND, 0, 0);
    checkVal("t4_err_code", 64'(err_code), 64'd2);
    checkVal("t4_ticks", ticks, 64'd18);
    checkVal("t4_ticks4_sat", 64'(ticks4), 64'd15);

    restartRun("t5");
    runInstr("t5_alu", C_ALU, 0, 0, 0, 0, 0, 0);
    pgm_ack = 1'b1; dec_class = 3'(C_MEM);
    tick();
    pgm_ack = 1'b0;
    tick();
    checkVal("t5_in_data_fetch", 64'(state), 64'd2);
    r_ctl = 8'h00;
    tick();
    checkVal("t5_data_req_dropped", 64'(data_req), 64'd0);
    checkVal("t5_state", 64'(state), 64'd0);
    checkVal("t5_ip", 64'(ip), 64'd0);
    checkVal("t5_ticks", ticks, 64'd0);
    checkVal("t5_status", 64'(r_status), 64'd0);
    tick();
    data_ack = 1'b1;
    #1;
    checkVal("t5_late_ack_wb", 64'(wb_en), 64'd0);
    tick();
    data_ack = 1'b0;
    checkVal("t5_wb_count", 64'(wbSeen), 64'(mWb));
    checkVal("t5_ip_after_ack", 64'(ip), 64'd0);
    r_ctl = 8'h01;
    #1;
    checkVal("t5_restart_pgm_req", 64'(pgm_req), 64'd1);
    mIp = 0; mTicks = 0; mHalt = 1'b0; mErr = 1'b0; mCode = 0;
    runInstr("t5_after_restart", C_ALU, 0, 0, 1, 0, 0, 0);

    restartRun("t6");
    runInstr("t6_jmp_end", C_JMP, 1, 4093, 0, 0, 0, 0);
    checkVal("t6_ip_4094", 64'(ip), 64'd4094);
    runInstr("t6_lddw_end", C_LDDW, 0, 0, 0, 0, 0, 0);
    checkVal("t6_lddw_err", 64'(err_code), 64'd1);
    restartRun("t6b");
    runInstr("t6_mem_ok", C_MEM, 0, 0, 0, 2, 0, 0);
    runInstr("t6_mem_both", C_MEM, 0, 0, 0, 1, 1, 1);
    checkVal("t6_data_err_code", 64'(err_code), 64'd3);

    restartRun("rnd");
    for (int n = 0; n < 250; n++) begin
      int r, cls, off, fw, cw;
      bit tk, de, db;
      r = int'($urandom_range(99));
      if (r < 35) cls = C_ALU;
      else if (r < 55) cls = C_JMP;
      else if (r < 65) cls = C_LDDW;
      else if (r < 75) cls = C_MEM;
      else if (r < 83) cls = C_DIV;
      else if (r < 91) cls = C_CALL;
      else if (r < 96) cls = C_EXIT;
      else cls = C_ILL;
      tk  = 1'($urandom_range(1));
      off = int'($urandom_range(40)) - 20;
      fw  = int'($urandom_range(2));
      cw  = ($urandom_range(19) == 0) ? PEND : int'($urandom_range(4));
      de  = ($urandom_range(9) == 0);
      db  = 1'($urandom_range(1));
      runInstr("rnd", cls, tk, off, fw, cw, de, db);
      if (mHalt) restartRun("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
